// File: rtl/spi_pkg.sv
// Shared SPI frame constants and FSM state encoding for the read and write decoders.
// Latency: none (declarations only).
// Backpressure: none; SPI has no flow control, the controller owns SCLK.
package spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int MAX_ADDR   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        SEND   = 3'd3,
        DONE   = 3'd4,
        IGNORE = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_cipo_readback_if.sv
// SPI pin bundle between the controller and the read-back transmitter.
// Latency: none (wires only).
// Backpressure: none; the controller drives nCS/COPI, the peripheral drives CIPO/cipo_oe.
interface spi_cipo_readback_if;

    logic nCS;
    logic COPI;
    logic CIPO;
    logic cipo_oe;

    modport master (
        output nCS,
        output COPI,
        input  CIPO,
        input  cipo_oe
    );

    modport slave (
        input  nCS,
        input  COPI,
        output CIPO,
        output cipo_oe
    );

endinterface

// File: rtl/spi_tx_shift.sv
// Read-data shifter: captures a byte on SCLK rise, launches it MSB-first on SCLK falls.
// Latency: captured byte's MSB appears on dout at the falling edge after the load edge.
// Backpressure: none; shifting follows shift_en on every falling edge.
module spi_tx_shift
    import spi_pkg::*;
(
    input  logic              SCLK,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              shift_en,
    output logic              dout
);

    logic [DATA_W-1:0] hold_q;
    logic              pend_q;
    logic [DATA_W-1:0] sr_q;

    // Snapshot the register on the load edge; later writes to it cannot disturb this frame.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            pend_q <= 1'b0;
        end else begin
            if (load) begin
                hold_q <= din;
            end
            pend_q <= load;
        end
    end

    // First falling edge after a load transfers the snapshot, later ones shift left.
    always_ff @(negedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (shift_en) begin
            sr_q <= pend_q ? hold_q : {sr_q[DATA_W-2:0], 1'b0};
        end
    end

    assign dout = sr_q[DATA_W-1];

endmodule

// File: rtl/spi_cipo_readback.sv
// SPI read-back: decodes read frames on COPI and returns the addressed register on CIPO.
// Latency: data MSB launched half an SCLK after the last address bit; rd_count at bit 16.
// Backpressure: none; nCS high aborts at once (pad released combinationally).
module spi_cipo_readback
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int CNT_W    = 8
) (
    input  logic               SCLK,
    input  logic               rst_n,
    spi_cipo_readback_if.slave spi,
    input  logic [DATA_W-1:0]  reg0,
    input  logic [DATA_W-1:0]  reg1,
    input  logic [DATA_W-1:0]  reg2,
    input  logic [DATA_W-1:0]  reg3,
    input  logic [DATA_W-1:0]  reg4,
    output logic               rd_err,
    output logic [CNT_W-1:0]   rd_count
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_CMD    = CMD;
    localparam logic [2:0] ST_ADDR   = ADDR;
    localparam logic [2:0] ST_SEND   = SEND;
    localparam logic [2:0] ST_DONE   = DONE;
    localparam logic [2:0] ST_IGNORE = IGNORE;

    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic              rw_q;
    logic [ADDR_W-2:0] addr_sr;
    logic [ADDR_W-1:0] addr_full;
    logic              addr_ok;
    logic              last_addr_bit;
    logic [DATA_W-1:0] sel_dat;
    logic              tx_load;
    logic              tx_dout;

    // The final address bit is taken straight from COPI on the decision edge.
    assign addr_full     = {addr_sr, spi.COPI};
    assign addr_ok       = addr_full < ADDR_W'(NUM_REGS);
    assign last_addr_bit = (state == ST_ADDR) && (bit_cnt == 4'd7);
    assign tx_load       = !spi.nCS && last_addr_bit && addr_ok;

    // Select the register addressed by the frame being decoded.
    always_comb begin
        sel_dat = '0;
        case (addr_full)
            7'd0:    sel_dat = reg0;
            7'd1:    sel_dat = reg1;
            7'd2:    sel_dat = reg2;
            7'd3:    sel_dat = reg3;
            7'd4:    sel_dat = reg4;
            default: sel_dat = '0;
        endcase
    end

    // Frame FSM with bit counter, address capture, sticky error and completed-read count.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rw_q     <= 1'b0;
            addr_sr  <= '0;
            rd_err   <= 1'b0;
            rd_count <= '0;
        end else if (spi.nCS) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 4'd1;
            case (state)
                ST_IDLE: begin
                    rw_q  <= spi.COPI;
                    state <= ST_CMD;
                end
                ST_CMD: begin
                    addr_sr <= {addr_sr[ADDR_W-3:0], spi.COPI};
                    state   <= rw_q ? ST_IGNORE : ST_ADDR;
                end
                ST_ADDR: begin
                    addr_sr <= {addr_sr[ADDR_W-3:0], spi.COPI};
                    if (last_addr_bit) begin
                        if (addr_ok) begin
                            state <= ST_SEND;
                        end else begin
                            rd_err <= 1'b1;
                            state  <= ST_IGNORE;
                        end
                    end
                end
                ST_SEND: begin
                    if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                        rd_count <= rd_count + CNT_W'(1);
                        state    <= ST_DONE;
                    end
                end
                ST_DONE, ST_IGNORE: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IGNORE;
                end
            endcase
        end
    end

    spi_tx_shift u_tx_shift (
        .SCLK     (SCLK),
        .rst_n    (rst_n),
        .load     (tx_load),
        .din      (sel_dat),
        .shift_en (state == ST_SEND),
        .dout     (tx_dout)
    );

    // Pad drive follows nCS combinationally so an abort releases CIPO immediately.
    assign spi.cipo_oe = !spi.nCS && (state == ST_SEND);
    assign spi.CIPO    = spi.cipo_oe ? tx_dout : 1'b0;

endmodule

// File: tb/tb_spi_cipo_readback.sv
// Bench for spi_cipo_readback: directed SPI frames, scoreboard of expected read bytes.
// Latency: expected bytes are checked as the 8th data bit is sampled.
// Backpressure: none; the bench is the SPI controller.
module tb_spi_cipo_readback;
    import spi_pkg::*;

    localparam int HALF = 10;

    logic       SCLK;
    logic       rst_n;
    logic [7:0] reg0, reg1, reg2, reg3, reg4;
    logic       rd_err;
    logic [7:0] rd_count;

    spi_cipo_readback_if bus ();

    spi_cipo_readback #(.NUM_REGS(5), .CNT_W(8)) dut (
        .SCLK     (SCLK),
        .rst_n    (rst_n),
        .spi      (bus),
        .reg0     (reg0),
        .reg1     (reg1),
        .reg2     (reg2),
        .reg3     (reg3),
        .reg4     (reg4),
        .rd_err   (rd_err),
        .rd_count (rd_count)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_count;
    logic       exp_err;
    logic       oe_seen;

    initial begin
        SCLK = 1'b0;
        forever #HALF SCLK = ~SCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples CIPO just before each rising edge, assembles bytes, compares against queue.
    initial begin
        logic [7:0] shreg;
        int         nbits;
        shreg = '0;
        nbits = 0;
        forever begin
            @(negedge SCLK);
            #(HALF - 2);
            if (rst_n && bus.cipo_oe) begin
                oe_seen = 1'b1;
                shreg   = {shreg[6:0], bus.CIPO};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_q.size() > 0) begin
                        check("cipo_byte", 32'(shreg), 32'(exp_q.pop_front()));
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL cipo_unexpected: got 0x%0h, expected no drive", shreg);
                    end
                end
            end else begin
                nbits = 0;
            end
        end
    end

    // One 16-bit frame. abort_k/rst_k: on the falling edge before rising edge k, raise nCS / pulse
    // rst_n instead of continuing. chg_k: on that falling edge reg3 is overwritten with chg_val.
    task automatic frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                         input int abort_k, input int rst_k, input int chg_k,
                         input logic [7:0] chg_val);
        logic [15:0] word;
        word = {rw, addr, data};
        for (int k = 1; k <= 16; k++) begin
            @(negedge SCLK);
            if (k == abort_k) begin
                #1;
                check("abort_oe_before", 32'(bus.cipo_oe), 32'd1);
                bus.nCS = 1'b1;
                #1;
                check("abort_oe_after", 32'(bus.cipo_oe), 32'd0);
                check("abort_cipo", 32'(bus.CIPO), 32'd0);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                break;
            end
            if (k == rst_k) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_cipo", 32'(bus.CIPO), 32'd0);
                check("rst_oe", 32'(bus.cipo_oe), 32'd0);
                check("rst_count", 32'(rd_count), 32'd0);
                check("rst_err", 32'(rd_err), 32'd0);
                bus.nCS = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                #2;
                rst_n = 1'b1;
                break;
            end
            if (k == chg_k) reg3 = chg_val;
            bus.nCS  = 1'b0;
            bus.COPI = word[16 - k];
        end
        @(negedge SCLK);
        bus.nCS  = 1'b1;
        bus.COPI = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.nCS   = 1'b1;
        bus.COPI  = 1'b0;
        reg0      = 8'h5A;
        reg1      = 8'h3C;
        reg2      = 8'hA5;
        reg3      = 8'h00;
        reg4      = 8'hFF;
        exp_count = 8'd0;
        exp_err   = 1'b0;
        oe_seen   = 1'b0;

        #35;
        check("reset_cipo", 32'(bus.CIPO), 32'd0);
        check("reset_oe", 32'(bus.cipo_oe), 32'd0);
        check("reset_err", 32'(rd_err), 32'd0);
        check("reset_count", 32'(rd_count), 32'd0);
        @(negedge SCLK);
        rst_n = 1'b1;
        @(negedge SCLK);

        // Read addr 2 -> 0xA5
        exp_q.push_back(8'hA5);
        frame(1'b0, 7'd2, 8'h00, 0, 0, 0, 8'h00);
        exp_count = exp_count + 8'd1;
        check("rd2_count", 32'(rd_count), 32'(exp_count));
        check("rd2_err", 32'(rd_err), 32'(exp_err));

        // Write frame 0x8155 never drives CIPO
        oe_seen = 1'b0;
        frame(1'b1, 7'd1, 8'h55, 0, 0, 0, 8'h00);
        check("wr_oe_seen", 32'(oe_seen), 32'd0);
        check("wr_count", 32'(rd_count), 32'(exp_count));
        check("wr_err", 32'(rd_err), 32'(exp_err));

        // Invalid read addr 7, then valid read addr 0 keeps the sticky error
        oe_seen = 1'b0;
        frame(1'b0, 7'd7, 8'h00, 0, 0, 0, 8'h00);
        exp_err = 1'b1;
        check("bad_oe_seen", 32'(oe_seen), 32'd0);
        check("bad_err", 32'(rd_err), 32'(exp_err));
        check("bad_count", 32'(rd_count), 32'(exp_count));
        exp_q.push_back(8'h5A);
        frame(1'b0, 7'd0, 8'h00, 0, 0, 0, 8'h00);
        exp_count = exp_count + 8'd1;
        check("rd0_err", 32'(rd_err), 32'(exp_err));
        check("rd0_count", 32'(rd_count), 32'(exp_count));

        // Read addr 4 aborted after rising edge 12, then a clean read of addr 4
        exp_q.push_back(8'hFF);
        frame(1'b0, 7'd4, 8'h00, 13, 0, 0, 8'h00);
        check("abort_count", 32'(rd_count), 32'(exp_count));
        exp_q.push_back(8'hFF);
        frame(1'b0, 7'd4, 8'h00, 0, 0, 0, 8'h00);
        exp_count = exp_count + 8'd1;
        check("rd4_count", 32'(rd_count), 32'(exp_count));

        // 256 reads of addr 3; counter wraps; mid-frame reg3 change shows up one frame later
        for (int i = 0; i < 256; i++) begin
            if (i != 1) reg3 = 8'(i * 7 + 1);
            exp_q.push_back(reg3);
            frame(1'b0, 7'd3, 8'h00, 0, 0, (i == 0) ? 10 : 0, 8'hC3);
            exp_count = exp_count + 8'd1;
            check("rd3_count", 32'(rd_count), 32'(exp_count));
        end
        check("rd3_err", 32'(rd_err), 32'(exp_err));

        // Reset in the middle of SEND, then read addr 1
        exp_q.push_back(8'hA5);
        frame(1'b0, 7'd2, 8'h00, 0, 12, 0, 8'h00);
        exp_count = 8'd0;
        exp_err   = 1'b0;
        @(negedge SCLK);
        exp_q.push_back(8'h3C);
        frame(1'b0, 7'd1, 8'h00, 0, 0, 0, 8'h00);
        exp_count = exp_count + 8'd1;
        check("post_rst_count", 32'(rd_count), 32'(exp_count));
        check("post_rst_err", 32'(rd_err), 32'(exp_err));

        repeat (2) @(negedge SCLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
